clk_gen_multi: RTL and testbench
================================

Name: clk_gen_multi

Overview:
- Synthesisable, multi-channel successor to the single fixed-period testbench clock generator.
- Produces NUM_CH independent clock/pulse streams from one master clock.
- Each channel has its own half-period, start phase offset, and mode: off, free-run, or counted burst.
- Drives stimulus clocks and reset-pulse sequences into co-simulated blocks. Replaces hard-coded delay-based generators with cycle-exact, runtime-programmable ones.

Parameters:
- NUM_CH, 4, number of output channels (>=1).
- CNT_W, 16, width of the half-period, phase and burst-count fields.
- CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), width of the channel select field.

Ports:
- clk  in  1  master clock; all state updates on the rising edge.
- _Reset  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration can be accepted this cycle.
- cfg_ch  in  CH_W  target channel.
- cfg_mode  in  2  00 OFF, 01 RUN, 10 BURST, 11 reserved (treated as OFF).
- cfg_half  in  CNT_W  half-period in master cycles; 0 is treated as 1.
- cfg_phase  in  CNT_W  idle cycles before the first rising edge.
- cfg_count  in  CNT_W  BURST pulse count.
- clk_out  out  NUM_CH  generated clocks, one bit per channel.
- busy  out  NUM_CH  channel not IDLE.
- done  out  NUM_CH  1-cycle pulse when a burst completes.

Behaviour:
- Reset (asynchronous assert, synchronous release): all channels IDLE; clk_out=0, busy=0, done=0; all counters 0.
- Handshake:
  - Accept when cfg_valid && cfg_ready at a clock edge.
  - cfg_ready is combinational: 1 if cfg_mode is OFF/reserved, or if channel cfg_ch is IDLE; otherwise 0.
  - A running channel must be turned OFF before it can be reprogrammed.
  - cfg_ch >= NUM_CH: request is accepted and ignored.
- Per-channel FSM, states IDLE, PHASE, HIGH, LOW, STOP:
  - IDLE + accepted RUN/BURST: latch half_eff = max(cfg_half,1), mode and pulses=cfg_count. Go to PHASE with cnt=cfg_phase.
  - IDLE + BURST with cfg_count=0: stay IDLE; done pulses on the cycle after the accept.
  - PHASE: if cnt==0, go to HIGH with clk_out=1 and cnt=half_eff-1; else decrement cnt. The first rise occurs cfg_phase+1 edges after the accept edge.
  - HIGH: if cnt==0, go to LOW with clk_out=0 and cnt=half_eff-1; else decrement. HIGH therefore lasts exactly half_eff cycles.
  - LOW, cnt==0, RUN: go to HIGH with clk_out=1.
  - LOW, cnt==0, BURST: if pulses==1, go to IDLE and pulse done for 1 cycle; else decrement pulses and go to HIGH.
  - LOW, cnt!=0: decrement cnt.
  - Accepted OFF while in PHASE or LOW: IDLE on the next edge; clk_out stays 0.
  - Accepted OFF while in HIGH: go to STOP, which finishes the current high half (no truncated pulse), then IDLE with clk_out=0. No done pulse for OFF.
  - OFF to an IDLE channel: no effect.
- Period is 2*half_eff cycles at 50% duty; no drift over any number of periods.
- Counters never wrap: cnt is reloaded at 0 and never decremented below 0.
- Channels are fully independent: simultaneous events on different channels do not interact, and only one config is accepted per cycle.
- _Reset asserted mid-operation: outputs go to 0 immediately. No done pulse on reset.

Decomposition:
- Shared package clk_gen_pkg holds:
  - mode typedef/constants MODE_OFF=2'b00, MODE_RUN=2'b01, MODE_BURST=2'b10;
  - FSM state enum (IDLE, PHASE, HIGH, LOW, STOP).
- Sub-module clk_gen_chan holds one channel's FSM, counters and outputs. The top level decodes cfg_ch, generates cfg_ready, and instantiates NUM_CH copies in a generate loop.

Test Plan:
- Reset, then RUN on ch0 with half=3, phase=0 -> clk_out[0] rises 1 edge after accept; high 3 cycles, low 3 cycles, period 6, checked over 20 periods.
- BURST on ch1 with half=1, phase=2, count=4 -> first rise 3 edges after accept; exactly 4 pulses of 1 high/1 low; done[1] pulses once on the last low end; busy[1] then 0.
- RUN ch2 with half=5, then OFF issued 2 cycles into a high half -> high continues 3 more cycles, then clk_out=0 and IDLE; reprogramming is possible on the next cycle.
- half=0 and BURST count=0 -> half treated as 1; count 0 gives no pulses and done the next cycle; RUN on a busy channel sees cfg_ready=0, and the request is held until that channel goes IDLE.
- All 4 channels RUN with half=1,2,3,4 simultaneously, with _Reset pulsed low mid-run -> independent correct periods; on reset all outputs are 0 immediately, with no done pulse.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// Shared definitions for the multi-channel clock/pulse generator.
//   - cfg_mode encodings (2'b11 is reserved and behaves like OFF)
//   - per-channel FSM state encoding
//   - mode_starts(): true for the modes that launch a channel
package clk_gen_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    PHASE,
    HIGH,
    LOW,
    STOP
  } chan_state_t;

  function automatic logic mode_starts(input logic [1:0] mode);
    return (mode == MODE_RUN) || (mode == MODE_BURST);
  endfunction

endpackage

// File: rtl/clk_gen_chan.sv
// One clock/pulse channel: phase delay, then 50% duty square wave with a
// half-period of half_eff master cycles, either free-running or for a
// counted number of pulses.
//
// Ports:
//   clk        master clock
//   rst_n      asynchronous active-low reset
//   cfg_we     an accepted configuration targets this channel
//   cfg_mode   OFF / RUN / BURST (reserved = OFF)
//   cfg_half   half-period in master cycles (0 behaves as 1)
//   cfg_phase  idle cycles before the first rising edge
//   cfg_count  number of pulses in BURST mode
//   clk_out    generated clock (registered)
//   busy       channel is not IDLE
//   done       one-cycle pulse when a burst completes
module clk_gen_chan
  import clk_gen_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic [CNT_W-1:0] cfg_phase,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             clk_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  chan_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] half, half_nxt;
  logic [CNT_W-1:0] pulses, pulses_nxt;
  logic             burst, burst_nxt;
  logic             done_q, done_nxt;
  logic             clk_q;
  logic             start, stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      half   <= '0;
      pulses <= '0;
      burst  <= 1'b0;
      done_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      half   <= half_nxt;
      pulses <= pulses_nxt;
      burst  <= burst_nxt;
      done_q <= done_nxt;
      // Output registered from the next state so the clock never glitches
      // on a multi-bit state decode. STOP is the tail of a high half.
      clk_q  <= (state_nxt == HIGH) || (state_nxt == STOP);
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    half_nxt   = half;
    pulses_nxt = pulses;
    burst_nxt  = burst;
    done_nxt   = 1'b0;
    start      = cfg_we && mode_starts(cfg_mode);
    stop       = cfg_we && !mode_starts(cfg_mode);

    case (state)
      IDLE: begin
        if (start) begin
          if ((cfg_mode == MODE_BURST) && (cfg_count == '0)) begin
            // Empty burst: nothing to generate, report completion at once.
            done_nxt = 1'b1;
          end else begin
            state_nxt  = PHASE;
            cnt_nxt    = cfg_phase;
            half_nxt   = (cfg_half == '0) ? CNT_ONE : cfg_half;
            burst_nxt  = (cfg_mode == MODE_BURST);
            pulses_nxt = cfg_count;
          end
        end
      end

      PHASE: begin
        if (stop) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = HIGH;
          cnt_nxt   = half - CNT_ONE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end

      HIGH: begin
        if (cnt == '0) begin
          // Last cycle of the high half: an OFF here loses nothing.
          if (stop) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = LOW;
            cnt_nxt   = half - CNT_ONE;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
          if (stop) begin
            state_nxt = STOP;
          end
        end
      end

      LOW: begin
        if (stop) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          if (burst && (pulses == CNT_ONE)) begin
            state_nxt  = IDLE;
            pulses_nxt = '0;
            done_nxt   = 1'b1;
          end else begin
            if (burst) begin
              pulses_nxt = pulses - CNT_ONE;
            end
            state_nxt = HIGH;
            cnt_nxt   = half - CNT_ONE;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end

      STOP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign clk_out = clk_q;
  assign busy    = (state != IDLE);
  assign done    = done_q;

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-channel runtime-programmable clock/pulse generator.
// A single valid/ready configuration port programs one channel per cycle.
//
// Ports:
//   clk        master clock
//   _Reset     asynchronous active-low reset (released synchronously)
//   cfg_valid  configuration request
//   cfg_ready  request can be accepted (OFF always; start only if idle)
//   cfg_ch     target channel; values >= NUM_CH are accepted and ignored
//   cfg_mode   OFF / RUN / BURST / reserved(=OFF)
//   cfg_half   half-period in master cycles (0 behaves as 1)
//   cfg_phase  idle cycles before the first rising edge
//   cfg_count  BURST pulse count
//   clk_out    generated clocks, one bit per channel
//   busy       channel not IDLE
//   done       one-cycle burst-complete pulse per channel
module clk_gen_multi
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              _Reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic [CNT_W-1:0]  cfg_phase,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);

  // Reset asserts asynchronously through both flops, deasserts after two
  // clean edges so every channel leaves reset on the same cycle.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge _Reset) begin
    if (!_Reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // One-hot channel select; an out-of-range cfg_ch selects nothing, so it
  // reads as ready and is silently dropped.
  logic [NUM_CH-1:0] sel;
  logic              accept;

  assign cfg_ready = !mode_starts(cfg_mode) || !(|(sel & busy));
  assign accept    = cfg_valid && cfg_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign sel[i] = (cfg_ch == CH_W'(i));

    clk_gen_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (accept && sel[i]),
      .cfg_mode  (cfg_mode),
      .cfg_half  (cfg_half),
      .cfg_phase (cfg_phase),
      .cfg_count (cfg_count),
      .clk_out   (clk_out[i]),
      .busy      (busy[i]),
      .done      (done[i])
    );
  end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Scoreboard bench for clk_gen_multi. Each accepted start/stop records a
// per-channel descriptor; expected {clk_out,busy,done} per cycle are derived
// in closed form from that descriptor and queued, then popped and compared
// one cycle at a time just after each rising edge.
module tb_clk_gen_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 2;
  localparam int NEVER  = 32'h3fff_ffff;

  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_RUN   = 2'b01;
  localparam logic [1:0] M_BURST = 2'b10;

  logic              clk = 1'b0;
  logic              rst_l;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_mode;
  logic [CNT_W-1:0]  cfg_half;
  logic [CNT_W-1:0]  cfg_phase;
  logic [CNT_W-1:0]  cfg_count;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] done;

  clk_gen_multi #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .CH_W   (CH_W)
  ) dut (
    .clk       (clk),
    ._Reset    (rst_l),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_half  (cfg_half),
    .cfg_phase (cfg_phase),
    .cfg_count (cfg_count),
    .clk_out   (clk_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]       cyc;
    logic [NUM_CH-1:0] ck;
    logic [NUM_CH-1:0] bz;
    logic [NUM_CH-1:0] dn;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Channel descriptors: accept edge, phase, effective half, pulses
  // (-1 = free run), and OFF edge relative to the accept edge.
  int d_act [NUM_CH];
  int d_acc [NUM_CH];
  int d_p   [NUM_CH];
  int d_h   [NUM_CH];
  int d_n   [NUM_CH];
  int d_koff[NUM_CH];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // {clk,busy,done} after edge k counted from the accept edge (k=0).
  function automatic logic [2:0] wave(input int k, input int p, input int h,
                                      input int n, input int koff);
    int rise, endk, t, hend;
    logic c, b, d;
    c = 1'b0; b = 1'b0; d = 1'b0;
    if (k < 0) return 3'b000;
    if (n == 0) return (k == 0) ? 3'b001 : 3'b000;
    rise = p + 1;
    endk = (n < 0) ? NEVER : rise + 2 * h * n;
    if (k < koff) begin
      if (k < endk) begin
        b = 1'b1;
        t = k - rise;
        c = (t >= 0) && ((t % (2 * h)) < h);
      end else if (k == endk) begin
        d = 1'b1;
      end
    end else begin
      t = koff - 1 - rise;
      if ((t >= 0) && ((t % (2 * h)) < h)) begin
        hend = rise + (t / (2 * h)) * 2 * h + h;
        if (k < hend) begin
          b = 1'b1;
          c = 1'b1;
        end
      end
    end
    return {c, b, d};
  endfunction

  function automatic exp_t expect_at(input int c);
    exp_t e;
    logic [2:0] w;
    e.cyc = c; e.ck = '0; e.bz = '0; e.dn = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (d_act[i] != 0) begin
        w = wave(c - d_acc[i], d_p[i], d_h[i], d_n[i], d_koff[i]);
        e.ck[i] = w[2];
        e.bz[i] = w[1];
        e.dn[i] = w[0];
      end
    end
    return e;
  endfunction

  task automatic push_window(input int from, input int len);
    for (int i = 0; i < len; i++) sb.push_back(expect_at(from + i));
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    while (sb.size() > 0 && int'(sb[0].cyc) < cyc) begin
      e = sb.pop_front();
      check_eq("sb_order", e.cyc, cyc);
    end
    if (sb.size() > 0 && int'(sb[0].cyc) == cyc) begin
      e = sb.pop_front();
      check_eq($sformatf("clk_out c%0d", cyc), 32'(clk_out), 32'(e.ck));
      check_eq($sformatf("busy c%0d", cyc),    32'(busy),    32'(e.bz));
      check_eq($sformatf("done c%0d", cyc),    32'(done),    32'(e.dn));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a request, hold it until accepted (bounded), update the model
  // for the accept edge and queue push_len expected cycles from there.
  task automatic send(input int ch, input logic [1:0] mode, input int half,
                      input int phase, input int count, input int push_len,
                      output logic rdy0);
    int waited;
    cfg_ch    = CH_W'(ch);
    cfg_mode  = mode;
    cfg_half  = half[CNT_W-1:0];
    cfg_phase = phase[CNT_W-1:0];
    cfg_count = count[CNT_W-1:0];
    cfg_valid = 1'b1;
    #1;
    rdy0   = cfg_ready;
    waited = 0;
    while (!cfg_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!cfg_ready) begin
      check_eq($sformatf("ready_timeout ch%0d", ch), 32'(cfg_ready), 32'd1);
      cfg_valid = 1'b0;
      return;
    end
    if (ch < NUM_CH) begin
      if (mode == M_RUN || mode == M_BURST) begin
        d_act[ch]  = 1;
        d_acc[ch]  = cyc + 1;
        d_p[ch]    = phase;
        d_h[ch]    = (half == 0) ? 1 : half;
        d_n[ch]    = (mode == M_RUN) ? -1 : count;
        d_koff[ch] = NEVER;
      end else if (d_act[ch] != 0) begin
        d_koff[ch] = cyc + 1 - d_acc[ch];
      end
    end
    if (push_len > 0) push_window(cyc + 1, push_len);
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r;
    for (int i = 0; i < NUM_CH; i++) begin
      d_act[i] = 0; d_acc[i] = 0; d_p[i] = 0; d_h[i] = 1; d_n[i] = 0; d_koff[i] = NEVER;
    end
    rst_l     = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_mode  = M_RUN;
    cfg_half  = '0;
    cfg_phase = '0;
    cfg_count = '0;

    // Reset state
    tick();
    check_eq("rst clk_out", 32'(clk_out), 32'd0);
    check_eq("rst busy",    32'(busy),    32'd0);
    check_eq("rst done",    32'(done),    32'd0);
    tick();
    rst_l = 1'b1;
    run(3);
    check_eq("idle ready", 32'(cfg_ready), 32'd1);

    // RUN ch0 half=3 phase=0 over 20 periods, then OFF in a high half
    send(0, M_RUN, 3, 0, 0, 122, r);
    check_eq("run0 ready", 32'(r), 32'd1);
    run(121);
    send(0, M_OFF, 0, 0, 0, 5, r);
    run(4);

    // BURST ch1 half=1 phase=2 count=4
    send(1, M_BURST, 1, 2, 4, 16, r);
    run(15);

    // RUN ch2 half=5, OFF two cycles into the second high half, reprogram
    send(2, M_RUN, 5, 0, 0, 13, r);
    run(12);
    send(2, M_OFF, 0, 0, 0, 4, r);
    run(3);
    send(2, M_BURST, 2, 0, 2, 12, r);
    check_eq("reprog ready", 32'(r), 32'd1);
    run(11);

    // BURST count=0: no pulses, done on the cycle after accept
    send(1, M_BURST, 7, 3, 0, 4, r);
    run(3);

    // half=0 burst on ch3, then a RUN held off while ch3 is busy
    send(3, M_BURST, 0, 1, 2, 7, r);
    send(3, M_RUN, 2, 0, 0, 12, r);
    check_eq("busy ready", 32'(r), 32'd0);
    run(11);
    send(3, M_OFF, 0, 0, 0, 6, r);
    run(5);

    // All four channels together, then reset mid-run
    send(0, M_RUN, 1, 0, 0, 0, r);
    send(1, M_RUN, 2, 0, 0, 0, r);
    send(2, M_RUN, 3, 0, 0, 0, r);
    send(3, M_RUN, 4, 0, 0, 30, r);
    run(29);
    #2;
    rst_l = 1'b0;
    #1;
    check_eq("async rst clk_out", 32'(clk_out), 32'd0);
    check_eq("async rst busy",    32'(busy),    32'd0);
    check_eq("async rst done",    32'(done),    32'd0);
    for (int i = 0; i < NUM_CH; i++) d_act[i] = 0;
    run(2);
    check_eq("in rst done", 32'(done), 32'd0);
    rst_l = 1'b1;
    run(3);
    push_window(cyc + 1, 5);
    run(5);

    check_eq("sb empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
